// File: rtl/operand_fetch_unit.sv
// Operand fetch: decode, scoreboard, forwarding and operand register.
// Sits between the instruction stream and execute, in front of the regfile.
module operand_fetch_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             instValid,
  output logic             instReady,
  input  logic [31:0]      instWord,
  output logic             opValid,
  input  logic             opReady,
  output logic [31:0]      opInstWord,
  output logic [XLEN-1:0]  opRs1Val,
  output logic [XLEN-1:0]  opRs2Val,
  output logic [4:0]       opRdAdrs,
  input  logic             wbValid,
  input  logic [4:0]       wbAdrs,
  input  logic [XLEN-1:0]  wbData,
  output logic             rfEnable,
  output logic [4:0]       rfRdAdrs,
  output logic [XLEN-1:0]  rfRdData,
  output logic [4:0]       rfRs1Adrs,
  output logic [4:0]       rfRs2Adrs,
  input  logic [XLEN-1:0]  rfRs1Data,
  input  logic [XLEN-1:0]  rfRs2Data,
  output logic [CNT_W-1:0] stallCount
);

  logic [6:0]      opc;
  logic [4:0]      rs1, rs2, rd;
  logic            use1, use2, used;
  logic [31:0]     wb_clr;
  logic [31:0]     busy_eff;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] rs1_val, rs2_val;

  logic             op_valid_q, op_valid_d;
  logic [31:0]      op_inst_q, op_inst_d;
  logic [XLEN-1:0]  op_rs1_q, op_rs1_d;
  logic [XLEN-1:0]  op_rs2_q, op_rs2_d;
  logic [4:0]       op_rd_q, op_rd_d;
  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  assign opc = instWord[6:0];
  assign rs1 = instWord[19:15];
  assign rs2 = instWord[24:20];
  assign rd  = instWord[11:7];

  assign rfRs1Adrs = rs1;
  assign rfRs2Adrs = rs2;

  // Writes to x0 never reach the file.
  assign rfEnable = wbValid && (wbAdrs != 5'd0);
  assign rfRdAdrs = wbAdrs;
  assign rfRdData = wbData;

  // Which register fields the opcode actually uses.
  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    used = 1'b0;
    unique case (opc)
      7'b0110011: begin
        use1 = 1'b1;
        use2 = 1'b1;
        used = 1'b1;
      end
      7'b0010011,
      7'b0000011,
      7'b1100111: begin
        use1 = 1'b1;
        used = 1'b1;
      end
      7'b0100011,
      7'b1100011: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      7'b0110111,
      7'b0010111,
      7'b1101111: used = 1'b1;
      default: ;
    endcase
  end

  // A same-cycle writeback retires its busy bit before the hazard check.
  always_comb begin
    wb_clr = 32'd0;
    if (wbValid) wb_clr[wbAdrs] = 1'b1;
    busy_eff = busy_q & ~wb_clr;
    busy_eff[0] = 1'b0;
    hazard = (use1 && busy_eff[rs1]) ||
             (use2 && busy_eff[rs2]) ||
             (used && busy_eff[rd]);
  end

  assign instReady = (!op_valid_q || opReady) && !hazard;
  assign accept    = instValid && instReady;

  // Operand mux: zero for unused or x0, then bypass, then file.
  always_comb begin
    rs1_val = rfRs1Data;
    if (!use1 || rs1 == 5'd0)
      rs1_val = '0;
    else if (wbValid && wbAdrs == rs1)
      rs1_val = wbData;
    rs2_val = rfRs2Data;
    if (!use2 || rs2 == 5'd0)
      rs2_val = '0;
    else if (wbValid && wbAdrs == rs2)
      rs2_val = wbData;
  end

  // Output bundle: load on accept, drop when consumed, else hold.
  always_comb begin
    op_valid_d = op_valid_q;
    op_inst_d  = op_inst_q;
    op_rs1_d   = op_rs1_q;
    op_rs2_d   = op_rs2_q;
    op_rd_d    = op_rd_q;
    if (accept) begin
      op_valid_d = 1'b1;
      op_inst_d  = instWord;
      op_rs1_d   = rs1_val;
      op_rs2_d   = rs2_val;
      op_rd_d    = used ? rd : 5'd0;
    end else if (opReady) begin
      op_valid_d = 1'b0;
    end
  end

  // Scoreboard: writeback clears, a new destination sets and wins.
  always_comb begin
    busy_d = busy_q & ~wb_clr;
    if (accept && used && rd != 5'd0)
      busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Count hazard stalls only, saturating.
  always_comb begin
    stall_d = stall_q;
    if (instValid && hazard && stall_q != {CNT_W{1'b1}})
      stall_d = stall_q + 1'b1;
  end

  // State registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      op_valid_q <= 1'b0;
      op_inst_q  <= '0;
      op_rs1_q   <= '0;
      op_rs2_q   <= '0;
      op_rd_q    <= '0;
      busy_q     <= '0;
      stall_q    <= '0;
    end else begin
      op_valid_q <= op_valid_d;
      op_inst_q  <= op_inst_d;
      op_rs1_q   <= op_rs1_d;
      op_rs2_q   <= op_rs2_d;
      op_rd_q    <= op_rd_d;
      busy_q     <= busy_d;
      stall_q    <= stall_d;
    end
  end

  assign opValid    = op_valid_q;
  assign opInstWord = op_inst_q;
  assign opRs1Val   = op_rs1_q;
  assign opRs2Val   = op_rs2_q;
  assign opRdAdrs   = op_rd_q;
  assign stallCount = stall_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit.
// Models the register file and checks hand-computed results.
module tb_operand_fetch_unit;

  logic        clock = 1'b0;
  logic        resetN;
  logic        instValid;
  logic        instReady;
  logic [31:0] instWord;
  logic        opValid;
  logic        opReady;
  logic [31:0] opInstWord;
  logic [31:0] opRs1Val;
  logic [31:0] opRs2Val;
  logic [4:0]  opRdAdrs;
  logic        wbValid;
  logic [4:0]  wbAdrs;
  logic [31:0] wbData;
  logic        rfEnable;
  logic [4:0]  rfRdAdrs;
  logic [31:0] rfRdData;
  logic [4:0]  rfRs1Adrs;
  logic [4:0]  rfRs2Adrs;
  logic [31:0] rfRs1Data;
  logic [31:0] rfRs2Data;
  logic [15:0] stallCount;

  logic [31:0] regs [32];

  int n_cmp = 0;
  int n_bad = 0;

  operand_fetch_unit #(.XLEN(32), .CNT_W(16)) dut (
    .clock(clock), .resetN(resetN),
    .instValid(instValid), .instReady(instReady),
    .instWord(instWord),
    .opValid(opValid), .opReady(opReady),
    .opInstWord(opInstWord),
    .opRs1Val(opRs1Val), .opRs2Val(opRs2Val),
    .opRdAdrs(opRdAdrs),
    .wbValid(wbValid), .wbAdrs(wbAdrs), .wbData(wbData),
    .rfEnable(rfEnable), .rfRdAdrs(rfRdAdrs),
    .rfRdData(rfRdData),
    .rfRs1Adrs(rfRs1Adrs), .rfRs2Adrs(rfRs2Adrs),
    .rfRs1Data(rfRs1Data), .rfRs2Data(rfRs2Data),
    .stallCount(stallCount)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (rfEnable) regs[rfRdAdrs] <= rfRdData;

  // x0 reads garbage so the unit must zero it itself.
  assign rfRs1Data = (rfRs1Adrs == 5'd0) ? 32'hDEADBEEF
                                         : regs[rfRs1Adrs];
  assign rfRs2Data = (rfRs2Adrs == 5'd0) ? 32'hDEADBEEF
                                         : regs[rfRs2Adrs];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rd,
                                        input logic [4:0] a,
                                        input logic [4:0] b);
    return {7'd0, b, a, 3'd0, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] rd,
                                        input logic [4:0] a,
                                        input logic [11:0] imm);
    return {imm, a, 3'd0, rd, 7'b0010011};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] wa, wb;
    resetN    = 1'b0;
    instValid = 1'b0;
    instWord  = 32'd0;
    opReady   = 1'b1;
    wbValid   = 1'b1;
    wbAdrs    = 5'd0;
    wbData    = 32'h55;
    #2;
    chk("rst_opvalid", opValid, 0);
    chk("rst_stall", stallCount, 0);
    chk("rst_ready", instReady, 1);
    chk("rst_inst", opInstWord, 0);
    chk("wb_x0_en", rfEnable, 0);
    tick();
    resetN = 1'b1;

    wbAdrs = 5'd1; wbData = 32'd20;
    #1;
    chk("wb_en", rfEnable, 1);
    chk("wb_adr", rfRdAdrs, 1);
    chk("wb_dat", rfRdData, 20);
    tick();
    wbAdrs = 5'd2; wbData = 32'd286;
    tick();
    wbAdrs = 5'd7; wbData = 32'h777;
    tick();
    wbValid = 1'b0;

    wa = rtype(5'd3, 5'd1, 5'd2);
    instWord = wa; instValid = 1'b1;
    #1;
    chk("add_ready", instReady, 1);
    tick();
    instValid = 1'b0;
    chk("add_valid", opValid, 1);
    chk("add_inst", opInstWord, wa);
    chk("add_rs1", opRs1Val, 20);
    chk("add_rs2", opRs2Val, 286);
    chk("add_rd", opRdAdrs, 3);
    tick();
    chk("drain", opValid, 0);

    instWord = itype(5'd4, 5'd0, 12'd5); instValid = 1'b1;
    tick();
    chk("addi_rd", opRdAdrs, 4);
    chk("addi_rs1", opRs1Val, 0);
    instWord = rtype(5'd5, 5'd4, 5'd4);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("raw_ready", instReady, 0);
      tick();
    end
    chk("raw_stall", stallCount, 3);
    wbValid = 1'b1; wbAdrs = 5'd4; wbData = 32'd1024;
    #1;
    chk("fwd_ready", instReady, 1);
    tick();
    wbValid = 1'b0;
    chk("fwd_rs1", opRs1Val, 1024);
    chk("fwd_rs2", opRs2Val, 1024);
    chk("fwd_rd", opRdAdrs, 5);
    chk("fwd_stall", stallCount, 3);

    instWord = rtype(5'd0, 5'd0, 5'd0);
    #1;
    chk("x0_ready", instReady, 1);
    tick();
    chk("x0_rs1", opRs1Val, 0);
    chk("x0_rs2", opRs2Val, 0);
    chk("x0_rd", opRdAdrs, 0);
    instWord = rtype(5'd8, 5'd0, 5'd0);
    #1;
    chk("x0_notbusy", instReady, 1);
    tick();
    instValid = 1'b0;
    tick();

    opReady = 1'b0;
    wa = itype(5'd9, 5'd1, 12'd7);
    wb = itype(5'd10, 5'd2, 12'd1);
    instWord = wa; instValid = 1'b1;
    tick();
    instWord = wb;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready", instReady, 0);
      tick();
      chk("bp_valid", opValid, 1);
      chk("bp_hold", opInstWord, wa);
      chk("bp_rs1", opRs1Val, 20);
    end
    chk("bp_stall", stallCount, 3);
    opReady = 1'b1;
    #1;
    chk("bp_release", instReady, 1);
    tick();
    instValid = 1'b0;
    chk("bp_next", opInstWord, wb);
    chk("bp_next_rs1", opRs1Val, 286);

    opReady = 1'b0;
    instWord = itype(5'd7, 5'd1, 12'd0); instValid = 1'b1;
    tick();
    instValid = 1'b0;
    chk("mr_valid", opValid, 1);
    #1;
    resetN = 1'b0;
    #1;
    chk("mr_opvalid", opValid, 0);
    chk("mr_inst", opInstWord, 0);
    chk("mr_stall", stallCount, 0);
    chk("mr_ready", instReady, 1);
    tick();
    resetN = 1'b1;
    opReady = 1'b1;
    instWord = rtype(5'd11, 5'd7, 5'd7); instValid = 1'b1;
    #1;
    chk("mr_x7_ready", instReady, 1);
    tick();
    chk("mr_x7_rs1", opRs1Val, 32'h777);
    chk("mr_x7_rd", opRdAdrs, 11);
    instWord = rtype(5'd12, 5'd3, 5'd3);
    #1;
    chk("mr_x3_ready", instReady, 1);
    tick();
    instValid = 1'b0;
    chk("mr_stall_end", stallCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
